// File: rtl/ddr_tx_gearbox_if.sv
// Word-side handshake into the gearbox: the producer drives data/valid,
// the gearbox answers with ready.
interface ddr_tx_gearbox_if #(
    parameter int DATA_WIDTH = 8
);
    logic [2*DATA_WIDTH-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/ddr_tx_gearbox.sv
// Word FIFO feeding a lo-then-hi serialiser that drives a DATA_WIDTH pin group
// on both clock edges (DDR) or on posedge only (SDR), chosen per word.
module ddr_tx_gearbox #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_VALUE = '0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    ddr_tx_gearbox_if.slave                   s_in,
    input  logic                              i_ddr_mode,
    output logic [DATA_WIDTH-1:0]             o_data_out,
    output logic                              o_data_out_valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_count
);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DDR, S_SDR_LO, S_SDR_HI} state_t;

    logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [PTR_W-1:0]        r_rd_ptr;
    logic [CNT_W-1:0]        r_count;
    logic                    r_run;
    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_sdr_hi;
    logic [DATA_WIDTH-1:0]   r_pos_x;
    logic                    r_pos_vx;
    logic [DATA_WIDTH-1:0]   r_hi_stage;
    logic                    r_hi_vld;
    logic [DATA_WIDTH-1:0]   r_neg_x;
    logic                    r_neg_vx;

    state_t                  w_next_state;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_nonempty;
    logic [2*DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0]   w_lo;
    logic [DATA_WIDTH-1:0]   w_hi;
    logic [DATA_WIDTH-1:0]   w_pos_val;
    logic                    w_pos_vld;
    logic [DATA_WIDTH-1:0]   w_stage_val;
    logic                    w_stage_vld;

    assign s_in.in_ready = r_run && rst_n && (r_count < DEPTH_C);
    assign w_push        = s_in.in_valid && s_in.in_ready;
    assign w_nonempty    = (r_count != '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_lo          = w_head[DATA_WIDTH-1:0];
    assign w_hi          = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign o_fifo_count  = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // SDR_LO is the only state that cannot accept a new word.
    always_comb begin
        w_next_state = r_state;
        if (r_state == S_SDR_LO) begin
            w_next_state = S_SDR_HI;
        end else if (w_nonempty) begin
            w_next_state = i_ddr_mode ? S_DDR : S_SDR_LO;
        end else begin
            w_next_state = S_IDLE;
        end
    end

    always_comb begin
        w_pop       = 1'b0;
        w_pos_val   = IDLE_VALUE;
        w_pos_vld   = 1'b0;
        w_stage_val = IDLE_VALUE;
        w_stage_vld = 1'b0;
        if (r_state == S_SDR_LO) begin
            w_pos_val   = r_sdr_hi;
            w_pos_vld   = 1'b1;
            w_stage_val = r_sdr_hi;
            w_stage_vld = 1'b1;
        end else if (w_nonempty) begin
            w_pop       = 1'b1;
            w_pos_val   = w_lo;
            w_pos_vld   = 1'b1;
            w_stage_val = i_ddr_mode ? w_hi : w_lo;
            w_stage_vld = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_run    <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_in.in_data;
        if (w_pop && !i_ddr_mode) r_sdr_hi <= w_hi;
    end

    // Posedge output stage: stores value^neg so that pos^neg shows the value
    // during the high phase without any clock-gated mux.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos_x    <= IDLE_VALUE;
            r_pos_vx   <= 1'b0;
            r_hi_stage <= IDLE_VALUE;
            r_hi_vld   <= 1'b0;
        end else begin
            r_pos_x    <= w_pos_val ^ r_neg_x;
            r_pos_vx   <= w_pos_vld ^ r_neg_vx;
            r_hi_stage <= w_stage_val;
            r_hi_vld   <= w_stage_vld;
        end
    end

    // Negedge output stage: stores stage^pos so pos^neg shows the low-phase value.
    always_ff @(negedge clk) begin
        r_neg_x  <= r_hi_stage ^ r_pos_x;
        r_neg_vx <= r_hi_vld ^ r_pos_vx;
    end

    assign o_data_out       = r_pos_x ^ r_neg_x;
    assign o_data_out_valid = r_pos_vx ^ r_neg_vx;
endmodule

// File: tb/tb_ddr_tx_gearbox.sv
// Directed bench for ddr_tx_gearbox with a queue-based half-period model
// checked on every phase, plus literal expectations per scenario.
module tb_ddr_tx_gearbox;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ddr_mode = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic [2:0]    fifo_count;

    ddr_tx_gearbox_if #(.DATA_WIDTH(DW)) s_if();

    ddr_tx_gearbox #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .IDLE_VALUE(8'h00)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_in             (s_if),
        .i_ddr_mode       (ddr_mode),
        .o_data_out       (data_out),
        .o_data_out_valid (data_out_valid),
        .o_fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is a queue; each posedge decides what the two halves
    // of the coming period must show.
    logic [15:0]   m_q[$];
    logic          m_run = 1'b0;
    logic          m_pend = 1'b0;
    logic [DW-1:0] m_sdr_hi = '0;
    logic [DW-1:0] m_hi = '0, m_lo = '0;
    logic          m_hv = 1'b0, m_lv = 1'b0;
    logic          m_hi_known = 1'b0, m_lo_known = 1'b0, m_prev_rst = 1'b0;

    always @(posedge clk) begin
        logic        can_push;
        logic [15:0] w;
        if (!rst_n) begin
            m_hi_known = m_prev_rst;
            m_prev_rst = 1'b1;
            m_lo_known = 1'b1;
            m_q.delete();
            m_pend = 1'b0;
            m_run  = 1'b0;
            m_hi = 8'h00; m_lo = 8'h00; m_hv = 1'b0; m_lv = 1'b0;
        end else begin
            m_hi_known = 1'b1;
            m_lo_known = 1'b1;
            m_prev_rst = 1'b0;
            can_push = s_if.in_valid && m_run && (m_q.size() < DEPTH);
            if (m_pend) begin
                m_hi = m_sdr_hi; m_lo = m_sdr_hi; m_hv = 1'b1; m_lv = 1'b1;
                m_pend = 1'b0;
            end else if (m_q.size() > 0) begin
                w = m_q.pop_front();
                m_hi = w[7:0]; m_hv = 1'b1; m_lv = 1'b1;
                if (ddr_mode) begin
                    m_lo = w[15:8];
                end else begin
                    m_lo = w[7:0];
                    m_pend = 1'b1;
                    m_sdr_hi = w[15:8];
                end
            end else begin
                m_hi = 8'h00; m_lo = 8'h00; m_hv = 1'b0; m_lv = 1'b0;
            end
            if (can_push) m_q.push_back(s_if.in_data);
            m_run = 1'b1;
        end
    end

    logic [8:0]    cap[$];
    logic [DW-1:0] cap_v[$];
    int            max_cnt = 0;
    logic          saw_not_ready = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (m_hi_known) begin
            chk("data_out_hi", data_out, m_hi);
            chk("valid_hi", data_out_valid, m_hv);
            cap.push_back({data_out_valid, data_out});
            if (data_out_valid) cap_v.push_back(data_out);
        end
        chk("in_ready", s_if.in_ready, rst_n && m_run && (m_q.size() < DEPTH));
        chk("fifo_count", fifo_count, m_q.size());
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        if (rst_n && !s_if.in_ready) saw_not_ready = 1'b1;
        @(negedge clk);
        #1;
        if (m_lo_known) begin
            chk("data_out_lo", data_out, m_lo);
            chk("valid_lo", data_out_valid, m_lv);
            cap.push_back({data_out_valid, data_out});
            if (data_out_valid) cap_v.push_back(data_out);
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push(input logic [15:0] w, input logic mode);
        s_if.in_data  = w;
        s_if.in_valid = 1'b1;
        ddr_mode      = mode;
        cycle();
        s_if.in_valid = 1'b0;
    endtask

    task automatic clear_cap();
        cap.delete();
        cap_v.delete();
        max_cnt = 0;
        saw_not_ready = 1'b0;
    endtask

    task automatic check_stream(input string name, input logic [8:0] exp[$]);
        chk({name, "_len"}, cap.size() >= exp.size(), 1);
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < cap.size()) ? cap[i] : 9'h1FF, exp[i]);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_q[$];
        logic       acc;
        int         tries;
        s_if.in_data  = '0;
        s_if.in_valid = 1'b0;

        // Reset then idle
        idle(3);
        chk("lit_ready_in_reset", s_if.in_ready, 0);
        rst_n = 1'b1;
        idle(3);
        chk("lit_ready_idle", s_if.in_ready, 1);
        chk("lit_count_idle", fifo_count, 0);
        chk("lit_out_idle_lo", data_out, 8'h00);
        chk("lit_vld_idle_lo", data_out_valid, 0);

        // DDR single word
        clear_cap();
        push(16'hB2A1, 1'b1);
        idle(3);
        exp_q = '{9'h000, 9'h000, 9'h1A1, 9'h1B2, 9'h000, 9'h000};
        check_stream("ddr_single", exp_q);

        // DDR burst of three
        clear_cap();
        push(16'h0201, 1'b1);
        push(16'h0403, 1'b1);
        push(16'h0605, 1'b1);
        idle(3);
        exp_q = '{9'h000, 9'h000, 9'h101, 9'h102, 9'h103, 9'h104,
                  9'h105, 9'h106, 9'h000, 9'h000};
        check_stream("ddr_burst", exp_q);
        chk("lit_burst_peak", max_cnt, 1);

        // SDR single word
        clear_cap();
        push(16'hCCDD, 1'b0);
        idle(3);
        exp_q = '{9'h000, 9'h000, 9'h1DD, 9'h1DD, 9'h1CC, 9'h1CC, 9'h000, 9'h000};
        check_stream("sdr_single", exp_q);

        // SDR overfill: pushes outpace pops until the FIFO is full
        clear_cap();
        ddr_mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            s_if.in_data  = {8'(8'hA0 + k), 8'(8'h50 + k)};
            s_if.in_valid = 1'b1;
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 40) begin
                acc = s_if.in_ready;
                cycle();
                tries++;
            end
            chk("full_accept", acc, 1);
        end
        s_if.in_valid = 1'b0;
        idle(25);
        chk("lit_full_peak", max_cnt, 4);
        chk("lit_saw_not_ready", saw_not_ready, 1);
        chk("full_stream_len", cap_v.size(), 32);
        for (int k = 0; k < 8; k++) begin
            chk("full_order", (4*k+0 < cap_v.size()) ? cap_v[4*k+0] : 8'hEE, 8'(8'h50 + k));
            chk("full_order", (4*k+1 < cap_v.size()) ? cap_v[4*k+1] : 8'hEE, 8'(8'h50 + k));
            chk("full_order", (4*k+2 < cap_v.size()) ? cap_v[4*k+2] : 8'hEE, 8'(8'hA0 + k));
            chk("full_order", (4*k+3 < cap_v.size()) ? cap_v[4*k+3] : 8'hEE, 8'(8'hA0 + k));
        end

        // Reset in the middle of a DDR burst
        clear_cap();
        push(16'h2211, 1'b1);
        push(16'h4433, 1'b1);
        push(16'h6655, 1'b1);
        rst_n = 1'b0;
        cycle();
        chk("lit_rst_lo_out", data_out, 8'h00);
        chk("lit_rst_lo_vld", data_out_valid, 0);
        chk("lit_rst_count", fifo_count, 0);
        cycle();
        rst_n = 1'b1;
        idle(2);
        push(16'h5AA5, 1'b1);
        idle(3);
        chk("rst_stream_len", cap_v.size(), 6);
        exp_q = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h0A5, 9'h05A};
        for (int i = 0; i < 6; i++)
            chk("rst_stream", (i < cap_v.size()) ? {1'b0, cap_v[i]} : 9'h1FF, exp_q[i]);

        // Mode change while an SDR word shows its high half
        clear_cap();
        push(16'h2010, 1'b0);
        push(16'h4030, 1'b0);
        cycle();
        ddr_mode = 1'b1;
        idle(3);
        exp_q = '{9'h000, 9'h000, 9'h110, 9'h110, 9'h120, 9'h120,
                  9'h130, 9'h140, 9'h000, 9'h000};
        check_stream("mode_switch", exp_q);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
